// File: rtl/bus_arbiter.sv
// Round-robin bus-drive arbiter for 25 register/port sources.
// Grants one source at a time, with registered one-hot grant, encoded select and status flags.
module bus_arbiter (
    input  logic        clk,
    input  logic        clr,
    input  logic [24:0] req,
    input  logic        hold,
    input  logic        en,
    output logic [24:0] grant,
    output logic [4:0]  sel,
    output logic        busy,
    output logic        multi
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    localparam logic [4:0] SEL_IDLE = 5'd31;
    localparam logic [4:0] LAST_IDX = 5'd24;

    logic [0:0]  state_q, state_d;
    logic [4:0]  ptr_q,   ptr_d;
    logic [24:0] grant_q, grant_d;
    logic [4:0]  sel_q,   sel_d;
    logic        busy_q,  busy_d;
    logic        multi_q, multi_d;

    logic [49:0] req_dbl;
    logic [49:0] req_rot_full;
    logic [24:0] req_rot;
    logic        win_found;
    logic [4:0]  win_off;
    logic [5:0]  win_sum;
    logic [5:0]  win_wrap;
    logic [4:0]  win_idx;
    logic        req_multi;
    logic        keep_owner;

    // Rotate requests so bit 0 corresponds to ptr; the lowest set bit is then the winner.
    assign req_dbl      = {req, req};
    assign req_rot_full = req_dbl >> ptr_q;
    assign req_rot      = req_rot_full[24:0];

    always_comb begin
        win_found = 1'b0;
        win_off   = 5'd0;
        for (int k = 24; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_found = 1'b1;
                win_off   = 5'(k);
            end
        end
    end

    assign win_sum   = {1'b0, ptr_q} + {1'b0, win_off};
    assign win_wrap  = win_sum - 6'd25;
    assign win_idx   = (win_sum >= 6'd25) ? win_wrap[4:0] : win_sum[4:0];
    assign req_multi = |(req & (req - 25'd1));

    // The owner's request is checked through its one-hot grant, so an idle select never indexes req.
    assign keep_owner = (state_q == ST_OWN) && hold && (|(req & grant_q));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        multi_d = multi_q;
        if (en && !keep_owner) begin
            if (win_found) begin
                state_d = ST_OWN;
                ptr_d   = (win_idx == LAST_IDX) ? 5'd0 : win_idx + 5'd1;
                grant_d = 25'd1 << win_idx;
                sel_d   = win_idx;
                busy_d  = 1'b1;
                multi_d = req_multi;
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
                sel_d   = SEL_IDLE;
                busy_d  = 1'b0;
                multi_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            ptr_q   <= 5'd0;
            grant_q <= '0;
            sel_q   <= SEL_IDLE;
            busy_q  <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            multi_q <= multi_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = busy_q;
    assign multi = multi_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios followed by random traffic,
// checked against a round-robin reference model kept in integer form.
module tb_bus_arbiter;

    logic        clk;
    logic        clr;
    logic [24:0] req;
    logic        hold;
    logic        en;
    logic [24:0] grant;
    logic [4:0]  sel;
    logic        busy;
    logic        multi;

    bus_arbiter dut (
        .clk   (clk),
        .clr   (clr),
        .req   (req),
        .hold  (hold),
        .en    (en),
        .grant (grant),
        .sel   (sel),
        .busy  (busy),
        .multi (multi)
    );

    typedef struct packed {
        logic [24:0] g;
        logic [4:0]  s;
        logic        b;
        logic        m;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference model: owner index (-1 when idle), pointer and multi flag.
    int m_own;
    int m_ptr;
    bit m_multi;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_own   = -1;
        m_ptr   = 0;
        m_multi = 1'b0;
    endfunction

    function automatic void model_step(input logic [24:0] r, input logic h, input logic e);
        int win;
        if (!e) return;
        if (m_own >= 0 && h && r[m_own]) return;
        win = -1;
        for (int k = 0; k < 25; k++) begin
            int idx;
            idx = (m_ptr + k) % 25;
            if (win < 0 && r[idx]) win = idx;
        end
        if (win < 0) begin
            m_own   = -1;
            m_multi = 1'b0;
        end else begin
            m_own   = win;
            m_ptr   = (win + 1) % 25;
            m_multi = ($countones(r) > 1);
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        if (m_own >= 0) begin
            e.g = 25'd1 << m_own;
            e.s = 5'(m_own);
            e.b = 1'b1;
        end else begin
            e.g = '0;
            e.s = 5'd31;
            e.b = 1'b0;
        end
        e.m = m_multi;
        return e;
    endfunction

    // Called at posedge+1; applies inputs for the next edge, then records the expected result.
    task automatic cycle(input logic [24:0] r, input logic h, input logic e, input bit do_clr);
        req  = r;
        hold = h;
        en   = e;
        @(posedge clk);
        #1;
        model_step(r, h, e);
        if (do_clr) begin
            clr = 1'b1;
            model_reset();
            #2;
            clr = 1'b0;
        end
        exp_q.push_back(model_out());
    endtask

    // Monitor: compares DUT outputs against the oldest expectation on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (grant !== e.g || sel !== e.s || busy !== e.b || multi !== e.m) begin
                    n_fail++;
                    $display("FAIL vec%0d outputs: got grant=%h sel=%0d busy=%0b multi=%0b, required grant=%h sel=%0d busy=%0b multi=%0b",
                             n_vec, grant, sel, busy, multi, e.g, e.s, e.b, e.m);
                end else if (!$onehot0(grant)) begin
                    n_fail++;
                    $display("FAIL vec%0d onehot: got grant=%h, required at most one bit", n_vec, grant);
                end else begin
                    $display("vec %0d ok grant=%h sel=%0d busy=%0b multi=%0b", n_vec, grant, sel, busy, multi);
                end
            end
        end
    end

    initial begin
        logic [24:0] r;
        clr  = 1'b1;
        req  = '0;
        hold = 1'b0;
        en   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        clr = 1'b0;
        exp_q.push_back(model_out());

        // PC alone after reset
        cycle(25'd1 << 20, 1'b0, 1'b1, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b1);

        // Two requesters alternate, multi set each time
        for (int i = 0; i < 4; i++) cycle((25'd1 << 4) | (25'd1 << 21), 1'b0, 1'b1, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b1);

        // Hold keeps owner 2 while 7 waits, then handover without gap
        cycle(25'd1 << 2, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle((25'd1 << 2) | (25'd1 << 7), 1'b1, 1'b1, 1'b0);
        cycle((25'd1 << 2) | (25'd1 << 7), 1'b0, 1'b1, 1'b0);

        // Wrap from 24 back to 0
        cycle(25'd1 << 24, 1'b0, 1'b1, 1'b0);
        cycle((25'd1 << 0) | (25'd1 << 23), 1'b0, 1'b1, 1'b0);
        cycle((25'd1 << 0) | (25'd1 << 23), 1'b0, 1'b1, 1'b0);

        // Drop to idle, then freeze with en=0
        cycle(25'd1 << 5, 1'b0, 1'b1, 1'b0);
        cycle('0, 1'b0, 1'b1, 1'b0);
        cycle(25'd1 << 5, 1'b0, 1'b0, 1'b0);
        cycle(25'd1 << 9, 1'b1, 1'b0, 1'b0);
        cycle(25'd1 << 9, 1'b0, 1'b1, 1'b0);
        cycle(25'd1 << 3, 1'b0, 1'b0, 1'b0);

        // Asynchronous clear while owned by 13, then restart from pointer 0
        cycle(25'd1 << 13, 1'b0, 1'b1, 1'b0);
        cycle(25'd1 << 13, 1'b1, 1'b1, 1'b1);
        cycle((25'd1 << 13) | (25'd1 << 3), 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: r = '0;
                1: r = 25'd1 << $urandom_range(0, 24);
                2: r = 25'($urandom) & 25'($urandom) & 25'($urandom);
                default: r = 25'($urandom);
            endcase
            cycle(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 85),
                  ($urandom_range(0, 99) < 3));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-002 Port: clr  input  1  reset; asynchronous, active-high.
REQ-003 Port: req  input  25  bus-drive requests; bit index = source code: R0..R15 = 0..15, HI 16, LO 17, Zhigh 18, Zlow 19, PC 20, MDR 21, MAR 22, In_Port 23, C 24.
REQ-004 Port: hold  input  1  current owner keeps the bus while hold=1 and its req bit stays 1.
REQ-005 Port: en  input  1  step enable; en=0 freezes all internal state and outputs.
REQ-006 Port: grant  output  25  one-hot bus-drive enables, same index map as req; all-zero when idle.
REQ-007 Port: sel  output  5  encoded index of the granted source, for the bus mux select; 5'd31 when idle.
REQ-008 Port: busy  output  1  1 while a grant is active.
REQ-009 Port: multi  output  1  1 when more than one req bit was set at the edge that produced the current grant.

Function
REQ-010 All outputs shall be registered; a req sampled at edge k shall appear on grant/sel at edge k (one-cycle latency, no combinational path from req to outputs).
REQ-011 The arbiter shall have two states: IDLE and OWN.
REQ-012 The arbiter shall hold a 5-bit round-robin pointer ptr in range 0..24.
REQ-013 Arbitration: scan upward from ptr with wrap 24->0; the first index with req=1 wins.
REQ-014 After a win at index i, ptr shall become i+1, or 0 when i=24.
REQ-015 IDLE, en=1, req nonzero: arbitrate; grant[i]=1, sel=i, busy=1, go to OWN.
REQ-016 IDLE, req zero: stay in IDLE; grant=0, sel=31, busy=0, multi=0.
REQ-017 OWN, en=1, hold=1, req[current]=1: keep grant, sel and multi unchanged; ptr unchanged.
REQ-018 OWN, en=1, hold=0 or req[current]=0: re-arbitrate the same cycle.
REQ-019 Re-arbitration shall use the updated ptr, so the previous owner has lowest priority; the previous owner may be re-granted only if it is the sole requester.
REQ-020 OWN, re-arbitration finds req zero: go to IDLE with idle output values.
REQ-021 Grant shall never have more than one bit set in any cycle.
REQ-022 Bus handover shall have no idle gap: the new grant replaces the old at the same edge.
REQ-023 en=0 shall hold state, ptr and all outputs regardless of req and hold.
REQ-024 Fairness: with hold=0, a continuously asserted requester shall be granted within 25 consecutive grant edges.
REQ-025 multi shall be recomputed only on arbitration edges (REQ-015, REQ-018), not on hold edges.
REQ-026 sel shall always equal the index of the set grant bit, or 31 when grant=0.

Reset
REQ-027 clr=1 shall immediately, regardless of clk, force: state IDLE, ptr=0, grant=0, sel=5'd31, busy=0, multi=0.
REQ-028 clr asserted mid-grant shall drop grant in the same cycle; the first arbitration after clr release shall start from ptr=0.
REQ-029 After clr deasserts, the first state change shall occur on the next rising clk edge with en=1.

Verification
REQ-030 Reset then req=1<<20 (PC), en=1, one edge -> grant=1<<20, sel=20, busy=1, multi=0.
REQ-031 From reset, req bits 4 and 21 held, hold=0, 4 edges -> sel sequence 4,21,4,21; multi=1 each edge.
REQ-032 Grant to 2 with hold=1, req[2] held, then req[7] added for 3 edges -> sel stays 2; drop hold -> next edge sel=7.
REQ-033 Wrap: after grant to 24, req bits 0 and 23 -> next edge sel=0, then sel=23.
REQ-034 Owner at 5, req goes to 0 -> next edge grant=0, sel=31, busy=0; en=0 with req nonzero -> outputs frozen.
REQ-035 clr pulsed between edges while sel=13 -> grant=0 and sel=31 before the next edge; req[13] and req[3] then -> sel=3.
